// File: rtl/bus_pkg.sv
// ---------------------------------------------------------------------------
// bus_pkg
// Shared definitions for the bus arbiter: arbitration FSM state encoding,
// the width of one per-port data/address slice, and a helper that sizes
// port-index vectors.
// ---------------------------------------------------------------------------
package bus_pkg;

  // Width of one packed per-port address / data slice.
  localparam int SLICE_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACTIVE  = 2'd1,
    ST_RELEASE = 2'd2
  } bus_state_t;

  // Bits needed to hold a port index; never less than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bus_arbiter_select.sv
// ---------------------------------------------------------------------------
// bus_arbiter_select
// Purely combinational winner selection.
//   request      in   NPORTS  pending request vector
//   pointer      in   IDX_W   index of the last granted port
//   round_robin  in   1       1 = search from pointer+1, 0 = port 0 highest
//   index        out  IDX_W   winning port (0 when nothing is pending)
//   valid        out  1       at least one request is pending
// ---------------------------------------------------------------------------
module bus_arbiter_select
  import bus_pkg::*;
#(
  parameter int NPORTS = 2,
  parameter int IDX_W  = idx_width(NPORTS)
) (
  input  logic [NPORTS-1:0] request,
  input  logic [IDX_W-1:0]  pointer,
  input  logic              round_robin,
  output logic [IDX_W-1:0]  index,
  output logic              valid
);

  int               cand;
  logic [IDX_W-1:0] cand_idx;

  always_comb begin
    index    = '0;
    valid    = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int i = 0; i < NPORTS; i++) begin
      // pointer + 1 + i never reaches 2*NPORTS, so one wrap is enough.
      if (round_robin) begin
        cand = int'(pointer) + 1 + i;
        if (cand >= NPORTS) cand = cand - NPORTS;
      end else begin
        cand = i;
      end
      cand_idx = IDX_W'(cand);
      if (!valid && request[cand_idx]) begin
        valid = 1'b1;
        index = cand_idx;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// ---------------------------------------------------------------------------
// bus_arbiter
// Multiplexes NPORTS request/ready masters onto one downstream bus.
// One transfer at a time: IDLE arbitrates, ACTIVE drives the bus for the
// latched winner until i_bus_ready or timeout, RELEASE waits for the winner
// to drop its request and the slave to drop ready.
//   i_clock, i_reset            clock, asynchronous active-high reset
//   o_bus_rw/request/address/wdata, i_bus_ready/rdata   downstream bus
//   i_p_rw, i_p_request, i_p_address, i_p_wdata         per-port requests
//   o_p_ready, o_p_error, o_p_rdata                     per-port completion
// Per-port 32-bit fields are packed with port k at [32k+31:32k].
// ---------------------------------------------------------------------------
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int NPORTS      = 2,
  parameter int ROUND_ROBIN = 1,
  parameter int TIMEOUT     = 1024
) (
  input  logic                      i_clock,
  input  logic                      i_reset,
  output logic                      o_bus_rw,
  output logic                      o_bus_request,
  input  logic                      i_bus_ready,
  output logic [SLICE_W-1:0]        o_bus_address,
  input  logic [SLICE_W-1:0]        i_bus_rdata,
  output logic [SLICE_W-1:0]        o_bus_wdata,
  input  logic [NPORTS-1:0]         i_p_rw,
  input  logic [NPORTS-1:0]         i_p_request,
  output logic [NPORTS-1:0]         o_p_ready,
  input  logic [SLICE_W*NPORTS-1:0] i_p_address,
  output logic [SLICE_W*NPORTS-1:0] o_p_rdata,
  input  logic [SLICE_W*NPORTS-1:0] i_p_wdata,
  output logic [NPORTS-1:0]         o_p_error
);

  localparam int               IDX_W        = idx_width(NPORTS);
  localparam logic [IDX_W-1:0] PTR_RESET    = IDX_W'(NPORTS - 1);
  localparam logic [31:0]      TIMEOUT_LAST = 32'(TIMEOUT - 1);
  localparam logic             RR_MODE      = (ROUND_ROBIN != 0);

  bus_state_t         state_reg, state_next;
  logic [IDX_W-1:0]   winner_reg, ptr_reg, sel_index;
  logic               sel_valid;
  logic [31:0]        count_reg;
  logic               complete, timed_out;
  logic [NPORTS-1:0]  ready_reg, error_reg;
  logic [SLICE_W-1:0] addr_slice  [NPORTS];
  logic [SLICE_W-1:0] wdata_slice [NPORTS];
  logic [SLICE_W-1:0] rdata_reg   [NPORTS];

  genvar gi;
  generate
    for (gi = 0; gi < NPORTS; gi++) begin : g_slice
      assign addr_slice[gi]                       = i_p_address[gi*SLICE_W +: SLICE_W];
      assign wdata_slice[gi]                      = i_p_wdata[gi*SLICE_W +: SLICE_W];
      assign o_p_rdata[gi*SLICE_W +: SLICE_W]     = rdata_reg[gi];
    end
  endgenerate

  assign o_p_ready = ready_reg;
  assign o_p_error = error_reg;

  bus_arbiter_select #(
    .NPORTS (NPORTS),
    .IDX_W  (IDX_W)
  ) u_select (
    .request     (i_p_request),
    .pointer     (ptr_reg),
    .round_robin (RR_MODE),
    .index       (sel_index),
    .valid       (sel_valid)
  );

  // State register. The bus request is decoded from state, so an async
  // reset drops it immediately.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) state_reg <= ST_IDLE;
    else         state_reg <= state_next;
  end

  always_comb begin
    state_next    = state_reg;
    complete      = 1'b0;
    timed_out     = 1'b0;
    o_bus_request = 1'b0;
    o_bus_rw      = 1'b0;
    o_bus_address = '0;
    o_bus_wdata   = '0;
    case (state_reg)
      ST_IDLE: begin
        if (sel_valid) state_next = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        o_bus_request = 1'b1;
        o_bus_rw      = i_p_rw[winner_reg];
        o_bus_address = addr_slice[winner_reg];
        o_bus_wdata   = wdata_slice[winner_reg];
        if (i_bus_ready) begin
          complete   = 1'b1;
          state_next = ST_RELEASE;
        end else if (TIMEOUT != 0 && count_reg == TIMEOUT_LAST) begin
          // count_reg holds the number of ACTIVE cycles already spent
          // without ready, so this is the TIMEOUT-th such cycle.
          timed_out  = 1'b1;
          state_next = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        if (!i_p_request[winner_reg] && !i_bus_ready) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Grant bookkeeping, timeout counter and per-port completion outputs.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      winner_reg <= '0;
      ptr_reg    <= PTR_RESET;
      count_reg  <= '0;
      ready_reg  <= '0;
      error_reg  <= '0;
      for (int i = 0; i < NPORTS; i++) rdata_reg[i] <= '0;
    end else begin
      ready_reg <= '0;
      error_reg <= '0;
      if (state_reg == ST_IDLE && sel_valid) begin
        winner_reg <= sel_index;
        ptr_reg    <= sel_index;
        count_reg  <= '0;
      end else if (state_reg == ST_ACTIVE) begin
        count_reg <= count_reg + 32'd1;
      end
      for (int i = 0; i < NPORTS; i++) begin
        if (winner_reg == IDX_W'(i)) begin
          if (complete) begin
            rdata_reg[i] <= i_bus_rdata;
            ready_reg[i] <= 1'b1;
          end else if (timed_out) begin
            rdata_reg[i] <= '0;
            ready_reg[i] <= 1'b1;
            error_reg[i] <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_bus_arbiter
// Directed bench for two arbiter configurations sharing clock and reset:
//   rr : NPORTS=2, round-robin, TIMEOUT=16
//   fx : NPORTS=4, fixed priority, TIMEOUT=16
// Inputs change and outputs are sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_bus_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // round-robin instance
  logic        rr_bus_rw, rr_bus_request, rr_bus_ready;
  logic [31:0] rr_bus_address, rr_bus_rdata, rr_bus_wdata;
  logic [1:0]  rr_p_rw, rr_p_request, rr_p_ready, rr_p_error;
  logic [63:0] rr_p_address, rr_p_rdata, rr_p_wdata;

  // fixed-priority instance
  logic         fx_bus_rw, fx_bus_request, fx_bus_ready;
  logic [31:0]  fx_bus_address, fx_bus_rdata, fx_bus_wdata;
  logic [3:0]   fx_p_rw, fx_p_request, fx_p_ready, fx_p_error;
  logic [127:0] fx_p_address, fx_p_rdata, fx_p_wdata;

  bus_arbiter #(.NPORTS(2), .ROUND_ROBIN(1), .TIMEOUT(16)) u_rr (
    .i_clock(clk), .i_reset(rst),
    .o_bus_rw(rr_bus_rw), .o_bus_request(rr_bus_request), .i_bus_ready(rr_bus_ready),
    .o_bus_address(rr_bus_address), .i_bus_rdata(rr_bus_rdata), .o_bus_wdata(rr_bus_wdata),
    .i_p_rw(rr_p_rw), .i_p_request(rr_p_request), .o_p_ready(rr_p_ready),
    .i_p_address(rr_p_address), .o_p_rdata(rr_p_rdata), .i_p_wdata(rr_p_wdata),
    .o_p_error(rr_p_error)
  );

  bus_arbiter #(.NPORTS(4), .ROUND_ROBIN(0), .TIMEOUT(16)) u_fx (
    .i_clock(clk), .i_reset(rst),
    .o_bus_rw(fx_bus_rw), .o_bus_request(fx_bus_request), .i_bus_ready(fx_bus_ready),
    .o_bus_address(fx_bus_address), .i_bus_rdata(fx_bus_rdata), .o_bus_wdata(fx_bus_wdata),
    .i_p_rw(fx_p_rw), .i_p_request(fx_p_request), .o_p_ready(fx_p_ready),
    .i_p_address(fx_p_address), .o_p_rdata(fx_p_rdata), .i_p_wdata(fx_p_wdata),
    .o_p_error(fx_p_error)
  );

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    n_vec++; if (rr_bus_request !== 1'b0) begin n_bad++; $display("FAIL reset_rr_bus_request: got %b expected 0", rr_bus_request); end
    n_vec++; if (rr_p_ready !== 2'b00 || rr_p_error !== 2'b00) begin n_bad++; $display("FAIL reset_rr_pulses: got ready=%b error=%b expected 00/00", rr_p_ready, rr_p_error); end
    n_vec++; if (rr_p_rdata !== 64'h0) begin n_bad++; $display("FAIL reset_rr_rdata: got %h expected 0", rr_p_rdata); end
    n_vec++; if (fx_bus_request !== 1'b0 || fx_bus_address !== 32'h0) begin n_bad++; $display("FAIL reset_fx_bus: got req=%b addr=%h expected 0/0", fx_bus_request, fx_bus_address); end
    n_vec++; if (fx_p_ready !== 4'h0 || fx_p_error !== 4'h0 || fx_p_rdata !== 128'h0) begin n_bad++; $display("FAIL reset_fx_outputs: got ready=%b error=%b rdata=%h expected zeros", fx_p_ready, fx_p_error, fx_p_rdata); end
    rst = 1'b0;
    $display("xfer: reset released");
  endtask

  // Both rr ports request together: port 0, then port 1, then port 0 again.
  task automatic test_rr_alternation();
    rr_p_address = {32'h0000_0200, 32'h0000_0100};
    rr_p_rw      = 2'b00;
    rr_p_request = 2'b11;
    @(negedge clk);
    n_vec++; if (rr_bus_request !== 1'b1 || rr_bus_address !== 32'h0000_0100) begin n_bad++; $display("FAIL rr_first_grant: got req=%b addr=%h expected 1/00000100", rr_bus_request, rr_bus_address); end
    rr_bus_ready = 1'b1; rr_bus_rdata = 32'hA0A0_0001;
    @(negedge clk);
    n_vec++; if (rr_p_ready !== 2'b01) begin n_bad++; $display("FAIL rr_first_ready: got %b expected 01", rr_p_ready); end
    n_vec++; if (rr_p_rdata[31:0] !== 32'hA0A0_0001) begin n_bad++; $display("FAIL rr_first_rdata: got %h expected a0a00001", rr_p_rdata[31:0]); end
    n_vec++; if (rr_bus_request !== 1'b0) begin n_bad++; $display("FAIL rr_release_bus_request: got %b expected 0", rr_bus_request); end
    $display("xfer: rr port0 read rdata=%h", rr_p_rdata[31:0]);
    rr_bus_ready = 1'b0; rr_p_request = 2'b10;
    @(negedge clk);
    n_vec++; if (rr_p_ready !== 2'b00 || rr_bus_request !== 1'b0) begin n_bad++; $display("FAIL rr_idle_gap: got ready=%b req=%b expected 00/0", rr_p_ready, rr_bus_request); end
    @(negedge clk);
    n_vec++; if (rr_bus_request !== 1'b1 || rr_bus_address !== 32'h0000_0200) begin n_bad++; $display("FAIL rr_second_grant: got req=%b addr=%h expected 1/00000200", rr_bus_request, rr_bus_address); end
    rr_bus_ready = 1'b1; rr_bus_rdata = 32'hB1B1_0002; rr_p_request = 2'b11;
    @(negedge clk);
    n_vec++; if (rr_p_ready !== 2'b10) begin n_bad++; $display("FAIL rr_second_ready: got %b expected 10", rr_p_ready); end
    n_vec++; if (rr_p_rdata !== 64'hB1B1_0002_A0A0_0001) begin n_bad++; $display("FAIL rr_second_rdata: got %h expected b1b10002a0a00001", rr_p_rdata); end
    $display("xfer: rr port1 read rdata=%h", rr_p_rdata[63:32]);
    rr_bus_ready = 1'b0; rr_p_request = 2'b01;
    @(negedge clk);
    @(negedge clk);
    n_vec++; if (rr_bus_request !== 1'b1 || rr_bus_address !== 32'h0000_0100) begin n_bad++; $display("FAIL rr_third_grant: got req=%b addr=%h expected 1/00000100", rr_bus_request, rr_bus_address); end
    rr_bus_ready = 1'b1; rr_bus_rdata = 32'hC0C0_0003;
    @(negedge clk);
    n_vec++; if (rr_p_ready !== 2'b01 || rr_p_rdata[31:0] !== 32'hC0C0_0003) begin n_bad++; $display("FAIL rr_third_ready: got ready=%b rdata=%h expected 01/c0c00003", rr_p_ready, rr_p_rdata[31:0]); end
    $display("xfer: rr port0 read rdata=%h", rr_p_rdata[31:0]);
    rr_bus_ready = 1'b0; rr_p_request = 2'b00;
    @(negedge clk);
  endtask

  // No slave ready: the 16th ACTIVE cycle ends the transfer with error.
  task automatic test_timeout();
    logic held_ok;
    held_ok = 1'b1;
    rr_p_request = 2'b01;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if (rr_bus_request !== 1'b1 || rr_p_ready !== 2'b00) held_ok = 1'b0;
    end
    n_vec++; if (held_ok !== 1'b1) begin n_bad++; $display("FAIL timeout_active_hold: got %b expected 1", held_ok); end
    @(negedge clk);
    n_vec++; if (rr_p_ready !== 2'b01 || rr_p_error !== 2'b01) begin n_bad++; $display("FAIL timeout_pulse: got ready=%b error=%b expected 01/01", rr_p_ready, rr_p_error); end
    n_vec++; if (rr_p_rdata[31:0] !== 32'h0) begin n_bad++; $display("FAIL timeout_rdata: got %h expected 0", rr_p_rdata[31:0]); end
    n_vec++; if (rr_bus_request !== 1'b0) begin n_bad++; $display("FAIL timeout_bus_request: got %b expected 0", rr_bus_request); end
    $display("xfer: rr port0 timeout error=%b", rr_p_error[0]);
    rr_p_request = 2'b00;
    @(negedge clk);
    n_vec++; if (rr_p_ready !== 2'b00 || rr_p_error !== 2'b00 || rr_bus_request !== 1'b0) begin n_bad++; $display("FAIL timeout_back_to_idle: got ready=%b error=%b req=%b expected 00/00/0", rr_p_ready, rr_p_error, rr_bus_request); end
  endtask

  // Port 1 write while port 0 also requests with distinct values.
  task automatic test_write();
    logic rw_ok, addr_ok, wdata_ok;
    rw_ok = 1'b1; addr_ok = 1'b1; wdata_ok = 1'b1;
    rr_p_address = {32'h2000_0010, 32'hBAD0_0000};
    rr_p_wdata   = {32'h1234_5678, 32'h0BAD_0BAD};
    rr_p_rw      = 2'b10;
    rr_p_request = 2'b11;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (rr_bus_rw !== 1'b1) rw_ok = 1'b0;
      if (rr_bus_address !== 32'h2000_0010) addr_ok = 1'b0;
      if (rr_bus_wdata !== 32'h1234_5678) wdata_ok = 1'b0;
    end
    n_vec++; if (rw_ok !== 1'b1) begin n_bad++; $display("FAIL write_rw: got %b expected 1", rw_ok); end
    n_vec++; if (addr_ok !== 1'b1) begin n_bad++; $display("FAIL write_address: got %b expected 1", addr_ok); end
    n_vec++; if (wdata_ok !== 1'b1) begin n_bad++; $display("FAIL write_wdata: got %b expected 1", wdata_ok); end
    rr_bus_ready = 1'b1; rr_bus_rdata = 32'h0;
    @(negedge clk);
    n_vec++; if (rr_p_ready !== 2'b10 || rr_p_error !== 2'b00) begin n_bad++; $display("FAIL write_ready: got ready=%b error=%b expected 10/00", rr_p_ready, rr_p_error); end
    n_vec++; if (rr_bus_rw !== 1'b0 || rr_bus_address !== 32'h0 || rr_bus_wdata !== 32'h0) begin n_bad++; $display("FAIL write_bus_idle: got rw=%b addr=%h wdata=%h expected 0/0/0", rr_bus_rw, rr_bus_address, rr_bus_wdata); end
    $display("xfer: rr port1 write addr=20000010 data=12345678");
    rr_bus_ready = 1'b0; rr_p_request = 2'b01;
    @(negedge clk);
    rr_p_request = 2'b00; rr_p_rw = 2'b00;
    @(negedge clk);
    n_vec++; if (rr_bus_request !== 1'b0) begin n_bad++; $display("FAIL write_no_regrant: got %b expected 0", rr_bus_request); end
  endtask

  // Reset during ACTIVE aborts without a pulse and restores port-0 priority.
  task automatic test_reset_abort();
    rr_p_address = {32'h0000_0200, 32'h0000_0100};
    rr_p_request = 2'b01;
    @(negedge clk);
    n_vec++; if (rr_bus_request !== 1'b1) begin n_bad++; $display("FAIL abort_active: got %b expected 1", rr_bus_request); end
    #2 rst = 1'b1; rr_bus_ready = 1'b1; rr_bus_rdata = 32'hFFFF_FFFF;
    #1;
    n_vec++; if (rr_bus_request !== 1'b0) begin n_bad++; $display("FAIL abort_async_drop: got %b expected 0", rr_bus_request); end
    @(negedge clk);
    n_vec++; if (rr_p_ready !== 2'b00 || rr_p_error !== 2'b00 || rr_p_rdata !== 64'h0) begin n_bad++; $display("FAIL abort_no_pulse: got ready=%b error=%b rdata=%h expected 00/00/0", rr_p_ready, rr_p_error, rr_p_rdata); end
    rst = 1'b0; rr_bus_ready = 1'b0; rr_p_request = 2'b11;
    @(negedge clk);
    n_vec++; if (rr_bus_request !== 1'b1 || rr_bus_address !== 32'h0000_0100) begin n_bad++; $display("FAIL abort_next_grant: got req=%b addr=%h expected 1/00000100", rr_bus_request, rr_bus_address); end
    rr_bus_ready = 1'b1; rr_bus_rdata = 32'h5555_0004;
    @(negedge clk);
    n_vec++; if (rr_p_ready !== 2'b01) begin n_bad++; $display("FAIL abort_next_ready: got %b expected 01", rr_p_ready); end
    $display("xfer: rr port0 after reset rdata=%h", rr_p_rdata[31:0]);
    rr_bus_ready = 1'b0; rr_p_request = 2'b00;
    @(negedge clk);
  endtask

  // Fixed priority: ports 1 and 3 keep requesting, port 1 always wins.
  task automatic test_fixed_priority();
    logic starved;
    starved = 1'b1;
    fx_p_address = {32'h0000_3333, 32'h0000_2222, 32'h0000_1111, 32'h0000_0000};
    fx_p_rw      = 4'b0000;
    fx_p_request = 4'b1010;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_vec++; if (fx_bus_request !== 1'b1 || fx_bus_address !== 32'h0000_1111) begin n_bad++; $display("FAIL fixed_grant_%0d: got req=%b addr=%h expected 1/00001111", k, fx_bus_request, fx_bus_address); end
      fx_bus_ready = 1'b1; fx_bus_rdata = 32'h100 + k;
      @(negedge clk);
      if (fx_p_ready[3] !== 1'b0) starved = 1'b0;
      n_vec++; if (fx_p_ready !== 4'b0010) begin n_bad++; $display("FAIL fixed_ready_%0d: got %b expected 0010", k, fx_p_ready); end
      $display("xfer: fx port1 read %0d rdata=%h", k, fx_p_rdata[63:32]);
      fx_bus_ready = 1'b0; fx_p_request = 4'b1000;
      @(negedge clk);
      if (fx_p_ready[3] !== 1'b0) starved = 1'b0;
      fx_p_request = (k == 2) ? 4'b0000 : 4'b1010;
    end
    n_vec++; if (starved !== 1'b1) begin n_bad++; $display("FAIL fixed_port3_starved: got %b expected 1", starved); end
    @(negedge clk);
    n_vec++; if (fx_bus_request !== 1'b0 || fx_p_ready !== 4'b0000) begin n_bad++; $display("FAIL fixed_end_idle: got req=%b ready=%b expected 0/0000", fx_bus_request, fx_p_ready); end
  endtask

  // Port 2 read, slave answers on the fifth ACTIVE cycle.
  task automatic test_read_latency();
    logic hold_ok;
    logic extra_pulse;
    hold_ok = 1'b1; extra_pulse = 1'b0;
    fx_p_address[95:64] = 32'h3000_0000;
    fx_p_rw      = 4'b0000;
    fx_p_request = 4'b0100;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (fx_bus_request !== 1'b1 || fx_bus_address !== 32'h3000_0000 || fx_bus_rw !== 1'b0 || fx_p_ready !== 4'b0000) hold_ok = 1'b0;
      if (c == 5) begin fx_bus_ready = 1'b1; fx_bus_rdata = 32'hDEAD_BEEF; end
    end
    n_vec++; if (hold_ok !== 1'b1) begin n_bad++; $display("FAIL read_active_hold: got %b expected 1", hold_ok); end
    @(negedge clk);
    n_vec++; if (fx_p_ready !== 4'b0100 || fx_p_error !== 4'b0000) begin n_bad++; $display("FAIL read_pulse: got ready=%b error=%b expected 0100/0000", fx_p_ready, fx_p_error); end
    n_vec++; if (fx_p_rdata[95:64] !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL read_rdata: got %h expected deadbeef", fx_p_rdata[95:64]); end
    $display("xfer: fx port2 read rdata=%h", fx_p_rdata[95:64]);
    fx_bus_ready = 1'b0; fx_bus_rdata = 32'h0; fx_p_request = 4'b0000;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (fx_p_ready !== 4'b0000 || fx_bus_request !== 1'b0) extra_pulse = 1'b1;
    end
    n_vec++; if (extra_pulse !== 1'b0) begin n_bad++; $display("FAIL read_single_pulse: got %b expected 0", extra_pulse); end
    n_vec++; if (fx_p_rdata[95:64] !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL read_rdata_held: got %h expected deadbeef", fx_p_rdata[95:64]); end
  endtask

  initial begin
    rst = 1'b1;
    rr_bus_ready = 1'b0; rr_bus_rdata = '0;
    rr_p_rw = '0; rr_p_request = '0; rr_p_address = '0; rr_p_wdata = '0;
    fx_bus_ready = 1'b0; fx_bus_rdata = '0;
    fx_p_rw = '0; fx_p_request = '0; fx_p_address = '0; fx_p_wdata = '0;
    test_reset();
    test_rr_alternation();
    test_timeout();
    test_write();
    test_reset_abort();
    test_fixed_priority();
    test_read_latency();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 SHALL have parameter NPORTS, default 2, number of requesting master ports (2..8).
REQ-002 SHALL have parameter ROUND_ROBIN, default 1; 1 = rotating priority, 0 = fixed priority (port 0 highest).
REQ-003 SHALL have parameter TIMEOUT, default 1024, max cycles a granted transfer waits for i_bus_ready; 0 disables the timeout.
REQ-004 i_clock  in  1  single clock; all state updates on rising edge.
REQ-005 i_reset  in  1  asynchronous, active-high reset.
REQ-006 o_bus_rw  out  1  downstream direction, 1 = write.
REQ-007 o_bus_request  out  1  downstream request level.
REQ-008 i_bus_ready  in  1  downstream completion.
REQ-009 o_bus_address  out  32  downstream address.
REQ-010 i_bus_rdata  in  32  downstream read data.
REQ-011 o_bus_wdata  out  32  downstream write data.
REQ-012 i_p_rw  in  NPORTS  per-port direction.
REQ-013 i_p_request  in  NPORTS  per-port request level, held by master until its ready is seen.
REQ-014 o_p_ready  out  NPORTS  per-port one-cycle completion pulse.
REQ-015 i_p_address  in  32*NPORTS  per-port address, port k at bits [32k+31:32k].
REQ-016 o_p_rdata  out  32*NPORTS  per-port read data, same packing, held until that port's next completion.
REQ-017 i_p_wdata  in  32*NPORTS  per-port write data, same packing.
REQ-018 o_p_error  out  NPORTS  per-port one-cycle pulse, coincident with o_p_ready, flagging timeout completion.

Function
REQ-019 SHALL implement states IDLE, ACTIVE, RELEASE.
REQ-020 IDLE: if any i_p_request bit set, select winner per priority mode, latch index, enter ACTIVE next edge; else remain.
REQ-021 Round-robin: search starts at (last granted index + 1) mod NPORTS; pointer updates only on grant.
REQ-022 ACTIVE: o_bus_request = 1; o_bus_rw/address/wdata driven from latched winner's inputs; all other outputs idle.
REQ-023 ACTIVE with i_bus_ready = 1: latch i_bus_rdata into winner's o_p_rdata, pulse o_p_ready[winner] next cycle, drop o_bus_request next cycle, enter RELEASE.
REQ-024 ACTIVE timeout: after TIMEOUT consecutive cycles without i_bus_ready, write 0 to winner's o_p_rdata, pulse o_p_ready and o_p_error for winner, drop o_bus_request, enter RELEASE.
REQ-025 RELEASE: return to IDLE when i_p_request[winner] = 0 and i_bus_ready = 0, same edge; no new grant issued from RELEASE.
REQ-026 Minimum back-to-back spacing: grant, ACTIVE >= 1 cycle, RELEASE >= 1 cycle, IDLE 1 cycle.
REQ-027 Requests withdrawn while ACTIVE are ignored; transfer completes normally.
REQ-028 Simultaneous requests: exactly one grant; losers wait in IDLE arbitration, no pulses.
REQ-029 Outside ACTIVE, o_bus_request = 0, o_bus_address/o_bus_wdata = 0, o_bus_rw = 0.
REQ-030 Timeout counter 32 bits, cleared on entry to ACTIVE.

Reset
REQ-031 On i_reset: state IDLE, o_p_ready = 0, o_p_error = 0, all o_p_rdata = 0, o_bus_request = 0, RR pointer = NPORTS-1 (port 0 wins first), timeout counter 0.
REQ-032 Reset mid-transfer SHALL abort immediately with no ready pulse; downstream sees o_bus_request fall asynchronously.

Structure
REQ-033 State encoding and port-slice width constant (32) SHALL live in shared package bus_pkg.
REQ-034 Winner selection SHALL be one sub-module bus_arbiter_select (request vector, pointer, mode -> index, valid), purely combinational.

Verification
REQ-035 NPORTS=2, RR: both request at once from reset -> port 0 granted, ready; then port 1 granted; port 0 again after.
REQ-036 NPORTS=4, fixed: ports 1,3 request continuously -> port 1 wins every arbitration, port 3 starved.
REQ-037 Read from port 2, slave ready after 5 cycles with rdata 0xDEADBEEF -> o_p_rdata[2] = 0xDEADBEEF, one o_p_ready[2] pulse, o_p_error = 0.
REQ-038 TIMEOUT=16, no slave ready -> after 16 cycles o_p_ready and o_p_error pulse for winner, o_p_rdata = 0, bus returns to IDLE.
REQ-039 Write port 1 addr 0x20000010 data 0x12345678 -> o_bus_rw = 1, address/wdata match for whole ACTIVE; port 0 inputs never appear.
REQ-040 Assert i_reset during ACTIVE -> o_bus_request = 0 immediately, no o_p_ready pulse, next grant goes to port 0.
